// File: rtl/id_stage_param.sv
// rtl/id_stage_param.sv - MIPS ID stage: register file with bypass, load-use stall, early branch, ID/EX register
module id_stage_param #(
   parameter int LEN                  = 32,
   parameter int CANTIDAD_REGISTROS   = 32,
   parameter int NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
   parameter int NB_CTRL_WB           = 2,
   parameter int NB_CTRL_MEM          = 9,
   parameter int NB_CTRL_EX           = 8,
   parameter int STALL_CYCLES         = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [LEN-1:0]                  i_instruccion,
   input  logic [LEN-1:0]                  i_adder_pc,
   input  logic                            i_valid,
   input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
   input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
   input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
   input  logic [LEN-1:0]                  i_write_data,
   input  logic                            i_RegWrite,
   input  logic                            i_flush,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt_ex,
   input  logic                            i_memread_ex,
   output logic [LEN-1:0]                  o_adder_pc,
   output logic [LEN-1:0]                  o_dato1,
   output logic [LEN-1:0]                  o_dato2,
   output logic [LEN-1:0]                  o_sign_extend,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_rs,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_rt,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_rd,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_shamt,
   output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
   output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
   output logic [NB_CTRL_EX-1:0]           o_ctrl_ex,
   output logic                            o_valid,
   output logic                            o_flag_stall,
   output logic                            o_branch_taken,
   output logic [LEN-1:0]                  o_branch_target
);

   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);

   logic [LEN-1:0]                  r_regs [CANTIDAD_REGISTROS];
   logic [2:0]                      r_cnt;

   logic [5:0]                      w_opcode;
   logic [NB_ADDRESS_REGISTROS-1:0] w_rs;
   logic [NB_ADDRESS_REGISTROS-1:0] w_rt;
   logic [NB_ADDRESS_REGISTROS-1:0] w_rd;
   logic [NB_ADDRESS_REGISTROS-1:0] w_shamt;
   logic [LEN-1:0]                  w_sign_extend;
   logic [LEN-1:0]                  w_dato1;
   logic [LEN-1:0]                  w_dato2;
   logic                            w_hz;
   logic                            w_eq;
   logic                            w_bubble;

   assign w_opcode      = i_instruccion[31:26];
   assign w_rs          = i_instruccion[21 +: NB_ADDRESS_REGISTROS];
   assign w_rt          = i_instruccion[16 +: NB_ADDRESS_REGISTROS];
   assign w_rd          = i_instruccion[11 +: NB_ADDRESS_REGISTROS];
   assign w_shamt       = i_instruccion[6 +: NB_ADDRESS_REGISTROS];
   assign w_sign_extend = {{(LEN-16){i_instruccion[15]}}, i_instruccion[15:0]};

   // Register file write port; r0 is never written so it always reads zero
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < CANTIDAD_REGISTROS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_RegWrite && (i_write_reg != '0)) begin
         r_regs[i_write_reg] <= i_write_data;
      end
   end

   // Read ports with write-through bypass so a same-cycle WB write is seen in ID
   always_comb begin
      w_dato1 = r_regs[w_rs];
      w_dato2 = r_regs[w_rt];
      if (w_rs == '0) begin
         w_dato1 = '0;
      end else if (i_RegWrite && (i_write_reg == w_rs)) begin
         w_dato1 = i_write_data;
      end
      if (w_rt == '0) begin
         w_dato2 = '0;
      end else if (i_RegWrite && (i_write_reg == w_rt)) begin
         w_dato2 = i_write_data;
      end
   end

   // Load-use hazard: the load in EX targets a source register of the ID instruction
   assign w_hz = i_valid & i_memread_ex & (i_rt_ex != '0) &
                 ((i_rt_ex == w_rs) | (i_rt_ex == w_rt));

   // A running counter keeps the stall alive and masks fresh hazard detection
   assign o_flag_stall = !i_flush & (((r_cnt == 3'd0) & w_hz) | (r_cnt != 3'd0));

   // Stall counter: loaded on a new hazard, counts down the remaining bubbles, cleared by flush
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= 3'd0;
      end else if (i_flush) begin
         r_cnt <= 3'd0;
      end else if (r_cnt != 3'd0) begin
         r_cnt <= r_cnt - 3'd1;
      end else if (w_hz) begin
         r_cnt <= STALL_LOAD;
      end
   end

   // Early branch resolution on the bypassed operands
   assign w_eq            = (w_dato1 == w_dato2);
   assign o_branch_taken  = i_valid & !o_flag_stall & !i_flush &
                            (((w_opcode == OP_BEQ) & w_eq) | ((w_opcode == OP_BNE) & !w_eq));
   assign o_branch_target = i_adder_pc + (w_sign_extend << 2);

   assign w_bubble = i_flush | o_flag_stall | !i_valid;

   // ID/EX register: data always loads, control and valid are zeroed for a bubble
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_adder_pc    <= '0;
         o_dato1       <= '0;
         o_dato2       <= '0;
         o_sign_extend <= '0;
         o_rs          <= '0;
         o_rt          <= '0;
         o_rd          <= '0;
         o_shamt       <= '0;
         o_ctrl_wb     <= '0;
         o_ctrl_mem    <= '0;
         o_ctrl_ex     <= '0;
         o_valid       <= 1'b0;
      end else begin
         o_adder_pc    <= i_adder_pc;
         o_dato1       <= w_dato1;
         o_dato2       <= w_dato2;
         o_sign_extend <= w_sign_extend;
         o_rs          <= w_rs;
         o_rt          <= w_rt;
         o_rd          <= w_rd;
         o_shamt       <= w_shamt;
         if (w_bubble) begin
            o_ctrl_wb  <= '0;
            o_ctrl_mem <= '0;
            o_ctrl_ex  <= '0;
            o_valid    <= 1'b0;
         end else begin
            o_ctrl_wb  <= i_ctrl_wb;
            o_ctrl_mem <= i_ctrl_mem;
            o_ctrl_ex  <= i_ctrl_ex;
            o_valid    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_param.sv
// tb/tb_id_stage_param.sv - directed scoreboard bench for id_stage_param
module tb_id_stage_param;

   localparam logic [1:0] CWB  = 2'b10;
   localparam logic [8:0] CMEM = 9'h1A2;
   localparam logic [7:0] CEX  = 8'h5C;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_instruccion, i_adder_pc, i_write_data;
   logic        i_valid, i_RegWrite, i_flush, i_memread_ex;
   logic [1:0]  i_ctrl_wb;
   logic [8:0]  i_ctrl_mem;
   logic [7:0]  i_ctrl_ex;
   logic [4:0]  i_write_reg, i_rt_ex;
   logic [31:0] o_adder_pc, o_dato1, o_dato2, o_sign_extend, o_branch_target;
   logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
   logic [1:0]  o_ctrl_wb;
   logic [8:0]  o_ctrl_mem;
   logic [7:0]  o_ctrl_ex;
   logic        o_valid, o_flag_stall, o_branch_taken;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic        v;
      logic        cd;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] d1;
      logic [31:0] d2;
   } exp_t;

   exp_t sb[$];

   id_stage_param #(.STALL_CYCLES(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_instruccion(i_instruccion), .i_adder_pc(i_adder_pc),
      .i_valid(i_valid), .i_ctrl_wb(i_ctrl_wb), .i_ctrl_mem(i_ctrl_mem), .i_ctrl_ex(i_ctrl_ex),
      .i_write_reg(i_write_reg), .i_write_data(i_write_data), .i_RegWrite(i_RegWrite),
      .i_flush(i_flush), .i_rt_ex(i_rt_ex), .i_memread_ex(i_memread_ex),
      .o_adder_pc(o_adder_pc), .o_dato1(o_dato1), .o_dato2(o_dato2), .o_sign_extend(o_sign_extend),
      .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
      .o_ctrl_wb(o_ctrl_wb), .o_ctrl_mem(o_ctrl_mem), .o_ctrl_ex(o_ctrl_ex), .o_valid(o_valid),
      .o_flag_stall(o_flag_stall), .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd3, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v, input logic fl,
                        input logic [4:0] rtex, input logic mrex,
                        input logic rw, input logic [4:0] wr, input logic [31:0] wd);
      i_instruccion = ins;
      i_adder_pc    = pc;
      i_valid       = v;
      i_flush       = fl;
      i_rt_ex       = rtex;
      i_memread_ex  = mrex;
      i_RegWrite    = rw;
      i_write_reg   = wr;
      i_write_data  = wd;
   endtask

   task automatic push(input string tag, input logic v, input logic cd,
                       input logic [31:0] d1, input logic [31:0] d2);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.cd  = cd;
      e.ins = i_instruccion;
      e.pc  = i_adder_pc;
      e.d1  = d1;
      e.d2  = d2;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t        e;
      logic [31:0] se;
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_valid"}, {31'd0, o_valid}, {31'd0, e.v});
         chk({e.tag, "_ctrl"}, {13'd0, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex},
             e.v ? {13'd0, CWB, CMEM, CEX} : 32'd0);
         if (e.cd) begin
            se = {{16{e.ins[15]}}, e.ins[15:0]};
            chk({e.tag, "_dato1"}, o_dato1, e.d1);
            chk({e.tag, "_dato2"}, o_dato2, e.d2);
            chk({e.tag, "_sext"}, o_sign_extend, se);
            chk({e.tag, "_pc"}, o_adder_pc, e.pc);
            chk({e.tag, "_fields"}, {12'd0, o_rs, o_rt, o_rd, o_shamt},
                {12'd0, e.ins[25:21], e.ins[20:16], e.ins[15:11], e.ins[10:6]});
         end
      end
   endtask

   task automatic comb(input string tag, input logic stall, input logic taken);
      #1;
      chk({tag, "_stall"}, {31'd0, o_flag_stall}, {31'd0, stall});
      chk({tag, "_taken"}, {31'd0, o_branch_taken}, {31'd0, taken});
   endtask

   initial begin
      i_ctrl_wb  = CWB;
      i_ctrl_mem = CMEM;
      i_ctrl_ex  = CEX;
      i_rst      = 1'b0;
      drive(rtype(5'd1, 5'd2, 5'd3), 32'h40, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 32'hFFFF);
      @(posedge i_clk);
      #1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ctrl", {13'd0, o_ctrl_wb, o_ctrl_mem, o_ctrl_ex}, 32'd0);
      chk("rst_dato1", o_dato1, 32'd0);
      chk("rst_pc", o_adder_pc, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b1;

      // preload r1 = r2 = 9 with ID idle
      drive(rtype(5'd1, 5'd2, 5'd3), 32'h40, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 32'd9);
      push("idle1", 1'b0, 1'b0, 0, 0);
      tick();
      drive(rtype(5'd1, 5'd2, 5'd3), 32'h44, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 32'd9);
      push("idle2", 1'b0, 1'b0, 0, 0);
      tick();

      // same-cycle WB write of r5 bypassed into add r3,r5,r0
      drive(rtype(5'd5, 5'd0, 5'd3), 32'h48, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h1234);
      comb("bypass", 1'b0, 1'b0);
      push("bypass", 1'b1, 1'b1, 32'h1234, 32'd0);
      tick();

      // write to r0 must neither bypass nor stick
      drive(rtype(5'd0, 5'd5, 5'd4), 32'h4C, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hDEAD);
      push("wr_r0", 1'b1, 1'b1, 32'd0, 32'h1234);
      tick();
      drive(rtype(5'd0, 5'd0, 5'd4), 32'h50, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      push("rd_r0", 1'b1, 1'b1, 32'd0, 32'd0);
      tick();

      // beq r1,r2,-1 at PC+4=0x100
      drive(itype(6'b000100, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("beq", 1'b0, 1'b1);
      chk("beq_target", o_branch_target, 32'hFC);
      push("beq", 1'b1, 1'b1, 32'd9, 32'd9);
      tick();
      drive(itype(6'b000101, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("bne_eq", 1'b0, 1'b0);
      push("bne_eq", 1'b1, 1'b1, 32'd9, 32'd9);
      tick();
      drive(itype(6'b000101, 5'd1, 5'd5, 16'h0004), 32'hFFFF_FFF0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("bne_ne", 1'b0, 1'b1);
      chk("bne_wrap", o_branch_target, 32'h0000_0000);
      push("bne_ne", 1'b1, 1'b1, 32'd9, 32'h1234);
      tick();

      // load-use on rs=7, three bubbles, r7 written during the stall and read on replay
      drive(rtype(5'd7, 5'd1, 5'd8), 32'h200, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0);
      comb("lu1", 1'b1, 1'b0);
      push("lu1", 1'b0, 1'b0, 0, 0);
      tick();
      drive(rtype(5'd7, 5'd1, 5'd8), 32'h200, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 32'h77);
      comb("lu2", 1'b1, 1'b0);
      push("lu2", 1'b0, 1'b0, 0, 0);
      tick();
      drive(rtype(5'd7, 5'd1, 5'd8), 32'h200, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("lu3", 1'b1, 1'b0);
      push("lu3", 1'b0, 1'b0, 0, 0);
      tick();
      comb("lu_issue", 1'b0, 1'b0);
      push("lu_issue", 1'b1, 1'b1, 32'h77, 32'd9);
      tick();

      // flush beats a running stall and a taken branch, and clears the counter
      drive(itype(6'b000100, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
      comb("fl_hz", 1'b1, 1'b0);
      push("fl_hz", 1'b0, 1'b0, 0, 0);
      tick();
      drive(itype(6'b000100, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
      comb("fl_on", 1'b0, 1'b0);
      push("fl_on", 1'b0, 1'b0, 0, 0);
      tick();
      drive(itype(6'b000100, 5'd1, 5'd2, 16'hFFFF), 32'h100, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("fl_after", 1'b0, 1'b1);
      push("fl_after", 1'b1, 1'b1, 32'd9, 32'd9);
      tick();

      // load into r0 in EX never stalls
      drive(rtype(5'd0, 5'd0, 5'd9), 32'h300, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      comb("lw_r0", 1'b0, 1'b0);
      push("lw_r0", 1'b1, 1'b1, 32'd0, 32'd0);
      tick();

      // hazard via rt, then asynchronous reset with cnt=1
      drive(rtype(5'd5, 5'd1, 5'd6), 32'h400, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 32'd0);
      comb("rt_hz", 1'b1, 1'b0);
      push("rt_hz", 1'b0, 1'b0, 0, 0);
      tick();
      drive(rtype(5'd5, 5'd1, 5'd6), 32'h400, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      push("rt_hz2", 1'b0, 1'b0, 0, 0);
      tick();
      comb("cnt1", 1'b1, 1'b0);
      #1;
      i_rst = 1'b0;
      #1;
      chk("arst_dato1", o_dato1, 32'd0);
      chk("arst_pc", o_adder_pc, 32'd0);
      chk("arst_rs", {27'd0, o_rs}, 32'd0);
      i_valid = 1'b0;
      #1;
      chk("arst_stall", {31'd0, o_flag_stall}, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b1;
      drive(rtype(5'd1, 5'd2, 5'd3), 32'h500, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
      comb("post_rst", 1'b0, 1'b0);
      push("post_rst", 1'b1, 1'b1, 32'd0, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised instruction-decode stage for the 5-stage MIPS pipeline, sitting between the IF/ID register and EX.
- Contains the register file with write-through bypass and load-use hazard detection with a configurable stall length.
- Resolves BEQ/BNE early in ID and produces a flush/target for IF.
- Registers all ID/EX outputs, including operands, on the rising edge, and takes the ctrl bundles from the existing control unit.

Parameters:
LEN, 32, datapath width
CANTIDAD_REGISTROS, 32, register-file depth
NB_ADDRESS_REGISTROS, $clog2(CANTIDAD_REGISTROS), register index width
NB_CTRL_WB, 2, WB control bundle width
NB_CTRL_MEM, 9, MEM control bundle width (bit 1 = MemRead)
NB_CTRL_EX, 8, EX control bundle width
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous, active-low reset
i_instruccion  in  LEN  instruction from IF/ID
i_adder_pc  in  LEN  PC+4 from IF/ID
i_valid  in  1  IF/ID holds a real instruction
i_ctrl_wb / i_ctrl_mem / i_ctrl_ex  in  NB_CTRL_*  control unit decode of i_instruccion
i_write_reg  in  NB_ADDRESS_REGISTROS  WB destination
i_write_data  in  LEN  WB data
i_RegWrite  in  1  WB write enable
i_flush  in  1  kill instruction in ID
i_rt_ex  in  NB_ADDRESS_REGISTROS  rt of instruction in EX
i_memread_ex  in  1  EX instruction is a load
o_adder_pc, o_dato1, o_dato2, o_sign_extend  out  LEN  registered ID/EX fields
o_rs, o_rt, o_rd, o_shamt  out  NB_ADDRESS_REGISTROS  registered fields ([25:21],[20:16],[15:11],[10:6])
o_ctrl_wb / o_ctrl_mem / o_ctrl_ex  out  NB_CTRL_*  registered control
o_valid  out  1  ID/EX holds a real instruction
o_flag_stall  out  1  combinational, hold PC and IF/ID
o_branch_taken  out  1  combinational, redirect IF and flush IF/ID
o_branch_target  out  LEN  combinational, i_adder_pc + (sign_extend << 2)

Behaviour:
- Reset (i_rst=0, asynchronous): all ID/EX outputs 0, o_valid 0, stall counter 0, all registers 0.
- Register file:
  - Write on rising edge when i_RegWrite and i_write_reg != 0.
  - Register 0 always reads 0.
- Bypass: read data equals i_write_data when i_RegWrite, i_write_reg == index and index != 0. Applies to rs and rt independently.
- Sign extend: bit 15 replicated to LEN.
- Hazard: hz = i_valid & i_memread_ex & (i_rt_ex != 0) & (i_rt_ex == rs | i_rt_ex == rt).
- Stall counter (3 bits):
  - When cnt == 0 and hz and !i_flush, load STALL_CYCLES-1.
  - When cnt != 0, decrement.
  - While cnt != 0, hz is ignored.
- o_flag_stall = !i_flush & ((cnt == 0 & hz) | cnt != 0).
- ID/EX update each cycle:
  - If i_flush, o_flag_stall or !i_valid: ctrl outputs 0 and o_valid 0. Data fields still load, so they are don't-care.
  - Otherwise all fields load and o_valid = 1.
- Branch:
  - Opcode 000100 (BEQ): taken when dato1 == dato2 (bypassed values).
  - Opcode 000101 (BNE): taken when dato1 != dato2.
  - Gated by i_valid & !o_flag_stall & !i_flush.
  - Target wraps modulo 2^LEN.
- i_flush has priority over hazard and branch. It also clears cnt to 0 on that edge.
- Simultaneous WB write and stall: the write still occurs. On the replay cycle, ID reads the new value.

Test Plan:
- Reset mid-stream with cnt=1 -> all outputs 0 immediately (asynchronous), o_flag_stall 0 once i_valid low.
- Write r5=0x1234 via WB while ID decodes add r3,r5,r0 in the same cycle -> o_dato1=0x1234 next edge. Write to r0 -> reads 0.
- EX lw rt=7, ID add rs=7, STALL_CYCLES=3 -> o_flag_stall high 3 cycles, 3 bubbles (o_valid 0, ctrl 0), then instruction issues with o_valid 1.
- beq r1,r2,-1 with r1=r2=9, i_adder_pc=0x100 -> o_branch_taken 1, o_branch_target 0xFC. bne with the same operands -> taken 0.
- i_flush together with hz and a taken beq -> o_flag_stall 0, o_branch_taken 0, bubble registered, cnt 0.
- lw rt=0 in EX, ID uses r0 -> no stall.
